// File: rtl/riscv_core_icache_pkg.sv
// I-cache refill shared types and AXI constants.
// Imported by the refill FSM and its line buffer.
package riscv_core_icache_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_DONE
  } refill_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int LINE_BITS = 256;
  localparam int BEAT_BITS = 64;
  localparam int BEATS     = LINE_BITS / BEAT_BITS;

endpackage

// File: rtl/riscv_core_icache_line_buf.sv
// Line assembly buffer for the I-cache refill.
// Each accepted beat lands in its slot of the line.
module riscv_core_icache_line_buf #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int BLOCK_WIDTH    = 256,
  parameter int IDX_WIDTH      = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_we,
  input  logic [IDX_WIDTH-1:0]      i_idx,
  input  logic [AXI_DATA_WIDTH-1:0] i_data,
  output logic [BLOCK_WIDTH-1:0]    o_line
);

  // Write the selected beat slot.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_line <= '0;
    end else if (i_we) begin
      o_line[i_idx*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= i_data;
    end
  end

endmodule

// File: rtl/riscv_core_icache_refill.sv
// I-cache refill: one AXI INCR burst per miss.
// Assembles the line and pulses valid or error.
module riscv_core_icache_refill
  import riscv_core_icache_pkg::*;
#(
  parameter int ADDR_WIDTH     = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int BLOCK_WIDTH    = 256,
  parameter int ID_WIDTH       = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_refill_req,
  input  logic [ADDR_WIDTH-1:0]     i_refill_addr,
  input  logic                      i_offset,
  output logic                      o_refill_busy,
  output logic [BLOCK_WIDTH-1:0]    o_block,
  output logic                      o_block_valid,
  output logic                      o_offset,
  output logic                      o_refill_err,
  output logic                      o_arvalid,
  input  logic                      i_arready,
  output logic [ADDR_WIDTH-1:0]     o_araddr,
  output logic [7:0]                o_arlen,
  output logic [2:0]                o_arsize,
  output logic [1:0]                o_arburst,
  output logic [ID_WIDTH-1:0]       o_arid,
  input  logic                      i_rvalid,
  output logic                      o_rready,
  input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]                i_rresp,
  input  logic                      i_rlast
);

  localparam int NB = BLOCK_WIDTH / AXI_DATA_WIDTH;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int OB = $clog2(BLOCK_WIDTH / 8);
  localparam logic [IW-1:0] LAST = IW'(NB - 1);
  localparam logic [ADDR_WIDTH-1:0] LMASK =
    ~{{(ADDR_WIDTH-OB){1'b0}}, {OB{1'b1}}};

  refill_state_t state, nstate;

  logic [ADDR_WIDTH-1:0] sum;
  logic [IW-1:0]         cnt;
  logic                  err;
  logic                  beat;
  logic                  bad;
  logic                  fin;

  assign sum  = i_offset ? i_refill_addr + ADDR_WIDTH'(2)
                         : i_refill_addr;
  assign beat = (state == S_R) && i_rvalid;
  assign fin  = i_rlast || (cnt == LAST);
  assign bad  = (i_rresp != AXI_RESP_OKAY) ||
                (i_rlast != (cnt == LAST));

  assign o_arlen   = 8'(NB - 1);
  assign o_arsize  = AXI_SIZE_8B;
  assign o_arburst = AXI_BURST_INCR;
  assign o_arid    = '0;

  // State register; reset abandons any burst.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= nstate;
  end

  // Next-state: one burst per accepted miss.
  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE: if (i_refill_req) nstate = S_AR;
      S_AR:   if (i_arready)    nstate = S_R;
      S_R:    if (i_rvalid && fin) nstate = S_DONE;
      S_DONE: nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  // State-decoded handshake and result strobes.
  always_comb begin
    o_refill_busy = (state != S_IDLE);
    o_arvalid     = (state == S_AR);
    o_rready      = (state == S_R);
    o_block_valid = (state == S_DONE) && !err;
    o_refill_err  = (state == S_DONE) && err;
  end

  // Latch the request, count beats, accumulate sticky error.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_araddr <= '0;
      o_offset <= 1'b0;
      cnt      <= '0;
      err      <= 1'b0;
    end else if (state == S_IDLE && i_refill_req) begin
      o_araddr <= sum & LMASK;
      o_offset <= i_offset;
      cnt      <= '0;
      err      <= 1'b0;
    end else if (beat) begin
      cnt      <= cnt + IW'(1);
      err      <= err | bad;
    end
  end

  riscv_core_icache_line_buf #(
    .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
    .BLOCK_WIDTH    (BLOCK_WIDTH),
    .IDX_WIDTH      (IW)
  ) u_buf (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_we   (beat),
    .i_idx  (cnt),
    .i_data (i_rdata),
    .o_line (o_block)
  );

endmodule

// File: tb/tb_riscv_core_icache_refill.sv
// Directed bench for the I-cache refill FSM.
// Inputs change and outputs are sampled on negedge.
module tb_riscv_core_icache_refill;

  logic         clk;
  logic         rst;
  logic         req;
  logic [63:0]  addr;
  logic         off;
  logic         busy;
  logic [255:0] blk;
  logic         bvalid;
  logic         ooff;
  logic         rerr;
  logic         arvalid;
  logic         arready;
  logic [63:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic [3:0]   arid;
  logic         rvalid;
  logic         rready;
  logic [63:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;

  int n_tests = 0;
  int n_fail  = 0;

  riscv_core_icache_refill dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_refill_req  (req),
    .i_refill_addr (addr),
    .i_offset      (off),
    .o_refill_busy (busy),
    .o_block       (blk),
    .o_block_valid (bvalid),
    .o_offset      (ooff),
    .o_refill_err  (rerr),
    .o_arvalid     (arvalid),
    .i_arready     (arready),
    .o_araddr      (araddr),
    .o_arlen       (arlen),
    .o_arsize      (arsize),
    .o_arburst     (arburst),
    .o_arid        (arid),
    .i_rvalid      (rvalid),
    .o_rready      (rready),
    .i_rdata       (rdata),
    .i_rresp       (rresp),
    .i_rlast       (rlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    check({tag, ".blk"}, blk, '0);
    check({tag, ".arvalid"}, arvalid, 0);
    check({tag, ".rready"}, rready, 0);
    check({tag, ".bvalid"}, bvalid, 0);
    check({tag, ".rerr"}, rerr, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".off"}, ooff, 0);
  endtask

  task automatic refill(input string tag,
                        input logic [63:0] a,
                        input logic o,
                        input int ar_dly,
                        input int gap,
                        input int bad_beat,
                        input int last,
                        input int rst_after,
                        input logic hold_req,
                        input logic [63:0] exp_ar);
    logic ex_err;
    ex_err = (bad_beat >= 0) || (last != 3);
    @(negedge clk);
    check({tag, ".idle"}, busy, 0);
    req  = 1'b1;
    addr = a;
    off  = o;
    @(negedge clk);
    req = hold_req;
    if (hold_req) begin
      addr = 64'h9000;
      off  = 1'b0;
    end
    check({tag, ".busy"}, busy, 1);
    check({tag, ".arlen"}, arlen, 3);
    check({tag, ".arsize"}, arsize, 3);
    check({tag, ".arburst"}, arburst, 1);
    check({tag, ".arid"}, arid, 0);
    check({tag, ".rr_ar"}, rready, 0);
    for (int i = 0; i < ar_dly; i++) begin
      check({tag, ".arv_w"}, arvalid, 1);
      check({tag, ".araddr_w"}, araddr, exp_ar);
      @(negedge clk);
    end
    check({tag, ".arvalid"}, arvalid, 1);
    check({tag, ".araddr"}, araddr, exp_ar);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    req     = 1'b0;
    check({tag, ".arv_off"}, arvalid, 0);
    for (int k = 0; k <= last; k++) begin
      for (int g = 0; g < gap; g++) begin
        rvalid = 1'b0;
        check({tag, ".rr_gap"}, rready, 1);
        @(negedge clk);
      end
      rvalid = 1'b1;
      rdata  = 64'hA + 64'(k);
      rresp  = (k == bad_beat) ? 2'b10 : 2'b00;
      rlast  = (k == last);
      check({tag, ".rready"}, rready, 1);
      @(negedge clk);
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
      if (k == rst_after) begin
        rst = 1'b1;
        #1;
        chk_zero({tag, ".rst"});
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end
    check({tag, ".bvalid"}, bvalid, !ex_err);
    check({tag, ".rerr"}, rerr, ex_err);
    check({tag, ".busy_d"}, busy, 1);
    check({tag, ".rr_d"}, rready, 0);
    check({tag, ".ooff"}, ooff, o);
    if (!ex_err)
      check({tag, ".blk"}, blk,
            {64'hD, 64'hC, 64'hB, 64'hA});
    @(negedge clk);
    check({tag, ".bv_end"}, bvalid, 0);
    check({tag, ".err_end"}, rerr, 0);
    check({tag, ".busy_end"}, busy, 0);
    check({tag, ".arv_end"}, arvalid, 0);
  endtask

  initial begin
    rst     = 1'b1;
    req     = 1'b0;
    addr    = '0;
    off     = 1'b0;
    arready = 1'b0;
    rvalid  = 1'b0;
    rdata   = '0;
    rresp   = 2'b00;
    rlast   = 1'b0;
    #1;
    chk_zero("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_zero("post_rst");

    refill("basic", 64'h1004, 1'b0, 0, 0, -1, 3, -1,
           1'b0, 64'h1000);
    refill("straddle", 64'h103E, 1'b1, 0, 0, -1, 3, -1,
           1'b0, 64'h1040);
    refill("slow", 64'h2468, 1'b0, 5, 2, -1, 3, -1,
           1'b1, 64'h2460);
    refill("slverr", 64'h4000, 1'b0, 1, 0, 2, 3, -1,
           1'b0, 64'h4000);
    refill("early_last", 64'h5020, 1'b0, 0, 0, -1, 1, -1,
           1'b0, 64'h5020);
    refill("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, 0,
           -1, 3, -1, 1'b0, 64'h0);
    refill("midrst", 64'h3000, 1'b1, 0, 0, -1, 3, 1,
           1'b0, 64'h3000);
    repeat (3) begin
      @(negedge clk);
      check("midrst.nopulse", bvalid, 0);
      check("midrst.noerr", rerr, 0);
      check("midrst.idle", busy, 0);
    end
    refill("after_rst", 64'h2010, 1'b0, 0, 1, -1, 3, -1,
           1'b0, 64'h2000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_core_icache_refill.md
RISCV_CORE_ICACHE_REFILL -- requirements
Module: riscv_core_icache_refill

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, meaning core address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 64, meaning AXI read-data beat width.
REQ-003 SHALL have parameter BLOCK_WIDTH, default 256, meaning cache line width (32 bytes, 8 instruction words).
REQ-004 SHALL have parameter ID_WIDTH, default 4, meaning AXI ID width.
REQ-005 SHALL use one clock and an asynchronous active-high reset, as the following ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous active-high reset.
- i_refill_req  in  1  miss request from the cache controller, sampled in IDLE only.
- i_refill_addr  in  ADDR_WIDTH  faulting fetch address.
- i_offset  in  1  selects the second line (addr+2) for instructions straddling a line boundary.
- o_refill_busy  out  1  high whenever the FSM is not in IDLE.
- o_block  out  BLOCK_WIDTH  assembled line for the cache memory.
- o_block_valid  out  1  one-cycle pulse; drives cache wr_en and block_replace.
- o_offset  out  1  registered i_offset, held with o_block.
- o_refill_err  out  1  one-cycle pulse on a failed refill.
- o_arvalid/i_arready  out/in  1  AR handshake.
- o_araddr  out  ADDR_WIDTH  line-aligned burst address.
- o_arlen  out  8  constant 3.
- o_arsize  out  3  constant 3.
- o_arburst  out  2  constant INCR (2'b01).
- o_arid  out  ID_WIDTH  constant 0.
- i_rvalid/o_rready  in/out  1  R handshake.
- i_rdata  in  AXI_DATA_WIDTH  beat data.
- i_rresp  in  2  beat response.
- i_rlast  in  1  last beat.

Function
REQ-006 SHALL implement FSM IDLE -> AR -> R -> DONE -> IDLE.
REQ-007 SHALL, in IDLE with i_refill_req=1, latch line address = (i_offset ? i_refill_addr+2 : i_refill_addr) with bits [4:0] cleared, latch i_offset, and enter AR.
REQ-008 SHALL assert o_arvalid in AR, starting the cycle after acceptance, holding o_araddr stable until i_arready; enter R on the handshake edge.
REQ-009 SHALL hold o_rready=1 only in R; each accepted beat k (2-bit counter, 0..3) writes o_block[64k+63:64k].
REQ-010 SHALL record a sticky error if any beat has i_rresp!=2'b00, if i_rlast=1 on beat<3, or if i_rlast=0 on beat 3.
REQ-011 SHALL leave R after beat 3, or on an early i_rlast, and enter DONE.
REQ-012 SHALL, in DONE, pulse o_block_valid for one cycle if no error, else pulse o_refill_err for one cycle with o_block_valid=0; then return to IDLE.
REQ-013 SHALL have a latency of one cycle from the last beat handshake to o_block_valid.
REQ-014 SHALL ignore i_refill_req while busy; at most one burst is outstanding.
REQ-015 SHALL perform 64-bit line-address arithmetic modulo 2^ADDR_WIDTH (wraps at top of memory).

Reset
REQ-016 SHALL, on i_rst, force IDLE and drive o_block=0, counter=0, error=0, and o_arvalid, o_rready, o_block_valid, o_refill_err, o_refill_busy, o_offset=0.
REQ-017 SHALL abandon a burst when reset arrives mid-burst and produce no block.

Structure
REQ-018 SHALL place the state enum, AXI burst/size/resp constants and BEATS=BLOCK_WIDTH/AXI_DATA_WIDTH in package riscv_core_icache_pkg.
REQ-019 SHALL implement beat assembly in one sub-module, riscv_core_icache_line_buf (beat index plus write enable, giving the 256-bit line).

Verification
REQ-020 SHALL cover: req addr 0x1004, offset 0, arready immediate, 4 OKAY beats 0xA..0xD -> araddr 0x1000, arlen 3; o_block={D,C,B,A}, pulse one cycle after rlast.
REQ-021 SHALL cover: addr 0x103E, offset 1 -> araddr 0x1040, o_offset=1.
REQ-022 SHALL cover: arready delayed 5 cycles, rvalid gaps -> araddr stable throughout; block correct.
REQ-023 SHALL cover: beat 2 with rresp=2'b10 -> all 4 beats consumed; o_refill_err pulse; o_block_valid=0.
REQ-024 SHALL cover: i_rst asserted after beat 1 -> all outputs 0 immediately; no pulse; next request completes normally.
